control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Time-step control unit of the processor datapath. Steps each instruction through T0..T3 and,
//  from the IR fields, drives the encoded register-select/enable pairs that feed the 3-to-8 register
//  decoders (Rin, Rout), plus the bus, ALU and IR load strobes. Sits between the IR register and the
//  register-select decoders / datapath muxes.
// PARAMETERS
//  OPW    3  opcode field width, IR[IRW-1 -: OPW]
//  RSW    3  register-select field width (X = IR[5:3], Y = IR[2:0])
//  IRW    9  instruction register width (III XXX YYY)
// PORTS
//  Clock     in   1    rising-edge clock
//  Reset     in   1    synchronous, active-high reset
//  Run       in   1    start request; sampled only in T0
//  IR        in   IRW  instruction register contents (loaded by IRin at end of T0)
//  Gnz       in   1    G register != 0 (used only with CTRL_MVNZ_EN)
//  IRin      out  1    load IR from DIN
//  Rin_sel   out  RSW  destination register index to decoder
//  Rin_en    out  1    destination decoder enable
//  Rout_sel  out  RSW  source register index to decoder
//  Rout_en   out  1    source decoder enable
//  DINout    out  1    drive DIN onto bus
//  Gout      out  1    drive G onto bus
//  Ain       out  1    load A from bus
//  Gin       out  1    load G from ALU
//  AddSub    out  1    0 = add, 1 = subtract
//  Done      out  1    last step of current instruction
// BEHAVIOUR
//  - State: 2-bit Tstep register {T0=00,T1=01,T2=10,T3=11}. All outputs combinational from Tstep+IR.
//  - Reset (sync): Tstep<=T0 next edge; reset overrides any step, mid-instruction included. During and
//    after reset, with Run=0, every output is 0 (sel outputs 0, enables 0).
//  - T0: IRin=Run. Run=1 -> T1; Run=0 -> stay T0. No other output active in T0.
//  - Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 1xx reserved.
//  - mv   T1: Rout_sel=Y, Rout_en=1, Rin_sel=X, Rin_en=1, Done=1.
//  - mvi  T1: DINout=1, Rin_sel=X, Rin_en=1, Done=1.
//  - add/sub T1: Rout_sel=X, Rout_en=1, Ain=1.  T2: Rout_sel=Y, Rout_en=1, Gin=1, AddSub=(op==011).
//                T3: Gout=1, Rin_sel=X, Rin_en=1, Done=1.
//  - Reserved opcodes: T1 asserts Done only (NOP).
//  - Done=1 -> next state T0 unconditionally; otherwise Tstep+1. T3 always has Done=1; no wrap T3->T0
//    without Done. Latency: mv/mvi 2 cycles incl. T0, add/sub 4 cycles.
//  - At most one bus driver (Rout_en, DINout, Gout) active per cycle; Rin_en and Rout_en never both
//    select the same step except mv (X<-Y, X==Y legal, no-op).
//  - Sel outputs are 0 whenever the matching enable is 0 (no X propagation to decoders).
//  - Run ignored outside T0; IR assumed stable from T1 to Done.
// CONFIGURATION
//  - CTRL_MVNZ_EN defined: opcode 100 = mvnz. T1: if Gnz=1 behaves as mv (move + Done); if Gnz=0
//    Done only. Opcodes 101-111 remain NOP.
//  - Undefined: opcode 100 is NOP; Gnz is unused.
// STRUCTURE
//  - Package proc_pkg: opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ), Tstep encodings
//    (T0..T3), field widths OPW/RSW/IRW.
//  - One sub-module: tstep_counter (2-bit, sync clear on Reset|Done, hold on T0&!Run).
//  - Output decode is a single combinational always block in control_sequencer.
// TESTING
//  1. Reset=1 two cycles, Run=1 -> Tstep=T0, all outputs 0; release -> IRin=1 in T0.
//  2. IR=000_011_101 (mv R3,R5) -> T1: Rout_sel=5,Rout_en=1,Rin_sel=3,Rin_en=1,Done=1; next cycle T0.
//  3. IR=001_110_000 (mvi R6) -> T1: DINout=1,Rin_sel=6,Rin_en=1,Done=1; Rout_en=0.
//  4. IR=011_001_010 (sub R1,R2) -> T1 Rout_sel=1,Ain; T2 Rout_sel=2,Gin,AddSub=1; T3 Gout,Rin_sel=1,Done.
//  5. add in progress, Reset=1 in T2 -> next cycle T0, all outputs 0; Run=0 in T0 -> stays T0, IRin=0.
//  6. IR=100_010_100: no macro -> T1 Done only; CTRL_MVNZ_EN, Gnz=1 -> mv R2<-R4; Gnz=0 -> Done only.

Source files
------------

// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Purpose : Shared constants and helpers for the processor control path.
//           Defines the instruction field widths, the opcode encodings, the
//           time-step (Tstep) encodings and a helper that splits an IR word
//           into its opcode / X / Y fields.
// Ports   : none (package)
// Config  : CTRL_MVNZ_EN (consumed by control_sequencer) enables the mvnz
//           opcode; the encoding OP_MVNZ is always defined here.
// -----------------------------------------------------------------------------
package proc_pkg;

    // Instruction format: III XXX YYY
    localparam int OPW = 3;
    localparam int RSW = 3;
    localparam int IRW = 9;

    // Opcodes (1xx reserved unless mvnz is enabled)
    localparam logic [OPW-1:0] OP_MV   = 3'b000;
    localparam logic [OPW-1:0] OP_MVI  = 3'b001;
    localparam logic [OPW-1:0] OP_ADD  = 3'b010;
    localparam logic [OPW-1:0] OP_SUB  = 3'b011;
    localparam logic [OPW-1:0] OP_MVNZ = 3'b100;

    // Time-step encodings
    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    typedef logic [1:0] tstep_t;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [RSW-1:0] x;
        logic [RSW-1:0] y;
    } ir_fields_t;

    // Split an instruction word into opcode, X and Y fields.
    function automatic ir_fields_t split_ir(input logic [IRW-1:0] ir);
        ir_fields_t f;
        f.op = ir[IRW-1 -: OPW];
        f.x  = ir[2*RSW-1 -: RSW];
        f.y  = ir[RSW-1:0];
        return f;
    endfunction

    // True for the two opcodes that use the A/G ALU path (T1..T3).
    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage : proc_pkg

// File: rtl/control_sequencer_tstep_counter.sv
// -----------------------------------------------------------------------------
// tstep_counter
// Purpose : 2-bit time-step register for the control sequencer.
//           Synchronously cleared to T0 on reset or when the current step is
//           the last of the instruction (Done); holds in T0 while Run is low;
//           otherwise advances by one step per clock.
// Ports   :
//   i_clock   in   1  rising-edge clock
//   i_reset   in   1  synchronous active-high reset
//   i_run     in   1  start request (only meaningful in T0)
//   i_done    in   1  last step of current instruction
//   o_tstep   out  2  current time step
// -----------------------------------------------------------------------------
module tstep_counter
    import proc_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic       i_done,
    output logic [1:0] o_tstep
);

    logic [1:0] r_tstep;
    logic [1:0] w_tstep_next;

    always_comb begin
        w_tstep_next = r_tstep;
        if (i_done) begin
            w_tstep_next = T0;
        end else if ((r_tstep == T0) && !i_run) begin
            w_tstep_next = T0;
        end else begin
            // T3 always raises Done, so this increment never wraps T3->T0.
            w_tstep_next = r_tstep + 2'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tstep <= T0;
        end else begin
            r_tstep <= w_tstep_next;
        end
    end

    assign o_tstep = r_tstep;

endmodule : tstep_counter

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Purpose : Time-step control unit of the processor datapath. Steps each
//           instruction through T0..T3 and decodes the IR fields into the
//           encoded register select/enable pairs for the Rin/Rout 3-to-8
//           decoders plus the bus, ALU and IR load strobes.
// Config  : `define CTRL_MVNZ_EN to make opcode 100 a conditional move (mvnz)
//           gated by i_gnz. Without it opcode 100 is a NOP and i_gnz is unused.
// Ports   :
//   i_clock     in   1    rising-edge clock
//   i_reset     in   1    synchronous active-high reset
//   i_run       in   1    start request, sampled only in T0
//   i_ir        in   IRW  instruction register (III XXX YYY)
//   i_gnz       in   1    G register != 0 (mvnz only)
//   o_irin      out  1    load IR from DIN
//   o_rin_sel   out  RSW  destination register index
//   o_rin_en    out  1    destination decoder enable
//   o_rout_sel  out  RSW  source register index
//   o_rout_en   out  1    source decoder enable
//   o_dinout    out  1    drive DIN onto bus
//   o_gout      out  1    drive G onto bus
//   o_ain       out  1    load A from bus
//   o_gin       out  1    load G from ALU
//   o_addsub    out  1    0 = add, 1 = subtract
//   o_done      out  1    last step of current instruction
// -----------------------------------------------------------------------------
module control_sequencer
    import proc_pkg::*;
(
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_run,
    input  logic [IRW-1:0] i_ir,
    input  logic           i_gnz,
    output logic           o_irin,
    output logic [RSW-1:0] o_rin_sel,
    output logic           o_rin_en,
    output logic [RSW-1:0] o_rout_sel,
    output logic           o_rout_en,
    output logic           o_dinout,
    output logic           o_gout,
    output logic           o_ain,
    output logic           o_gin,
    output logic           o_addsub,
    output logic           o_done
);

    logic [1:0]  w_tstep;
    ir_fields_t  w_f;

    assign w_f = split_ir(i_ir);

`ifdef CTRL_MVNZ_EN
    logic w_mvnz_take;
    assign w_mvnz_take = i_gnz;
`else
    // Gnz has no function without mvnz; tie it off so it is visibly unused.
    logic w_unused_gnz;
    assign w_unused_gnz = i_gnz;
`endif

    tstep_counter u_tstep (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_run   (i_run),
        .i_done  (o_done),
        .o_tstep (w_tstep)
    );

    // Output decode. Everything defaults to zero so select lines stay 0
    // whenever their enable is low, and the whole block is forced quiet
    // while reset is asserted (even if the step register is mid-instruction
    // or Run is high).
    always_comb begin
        o_irin     = 1'b0;
        o_rin_sel  = '0;
        o_rin_en   = 1'b0;
        o_rout_sel = '0;
        o_rout_en  = 1'b0;
        o_dinout   = 1'b0;
        o_gout     = 1'b0;
        o_ain      = 1'b0;
        o_gin      = 1'b0;
        o_addsub   = 1'b0;
        o_done     = 1'b0;

        if (!i_reset) begin
            case (w_tstep)
                T0: begin
                    o_irin = i_run;
                end

                T1: begin
                    case (w_f.op)
                        OP_MV: begin
                            o_rout_sel = w_f.y;
                            o_rout_en  = 1'b1;
                            o_rin_sel  = w_f.x;
                            o_rin_en   = 1'b1;
                            o_done     = 1'b1;
                        end
                        OP_MVI: begin
                            o_dinout  = 1'b1;
                            o_rin_sel = w_f.x;
                            o_rin_en  = 1'b1;
                            o_done    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            o_rout_sel = w_f.x;
                            o_rout_en  = 1'b1;
                            o_ain      = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            if (w_mvnz_take) begin
                                o_rout_sel = w_f.y;
                                o_rout_en  = 1'b1;
                                o_rin_sel  = w_f.x;
                                o_rin_en   = 1'b1;
                            end
                            o_done = 1'b1;
                        end
`endif
                        default: begin
                            // Reserved opcode: single-step NOP.
                            o_done = 1'b1;
                        end
                    endcase
                end

                T2: begin
                    if (is_alu_op(w_f.op)) begin
                        o_rout_sel = w_f.y;
                        o_rout_en  = 1'b1;
                        o_gin      = 1'b1;
                        o_addsub   = (w_f.op == OP_SUB);
                    end else begin
                        // Only reachable if IR changed mid-instruction;
                        // end the instruction rather than drift into T3.
                        o_done = 1'b1;
                    end
                end

                default: begin // T3
                    if (is_alu_op(w_f.op)) begin
                        o_gout    = 1'b1;
                        o_rin_sel = w_f.x;
                        o_rin_en  = 1'b1;
                    end
                    // T3 is always the final step.
                    o_done = 1'b1;
                end
            endcase
        end
    end

endmodule : control_sequencer

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic       clk;
    logic       reset;
    logic       run;
    logic [8:0] ir;
    logic       gnz;

    logic       o_irin;
    logic [2:0] o_rin_sel;
    logic       o_rin_en;
    logic [2:0] o_rout_sel;
    logic       o_rout_en;
    logic       o_dinout;
    logic       o_gout;
    logic       o_ain;
    logic       o_gin;
    logic       o_addsub;
    logic       o_done;

    control_sequencer dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_run      (run),
        .i_ir       (ir),
        .i_gnz      (gnz),
        .o_irin     (o_irin),
        .o_rin_sel  (o_rin_sel),
        .o_rin_en   (o_rin_en),
        .o_rout_sel (o_rout_sel),
        .o_rout_en  (o_rout_en),
        .o_dinout   (o_dinout),
        .o_gout     (o_gout),
        .o_ain      (o_ain),
        .o_gin      (o_gin),
        .o_addsub   (o_addsub),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed observation: {irin, rin_sel, rin_en, rout_sel, rout_en,
    //                      dinout, gout, ain, gin, addsub, done}
    logic [14:0] got;
    assign got = {o_irin, o_rin_sel, o_rin_en, o_rout_sel, o_rout_en,
                  o_dinout, o_gout, o_ain, o_gin, o_addsub, o_done};

    typedef struct {
        string       name;
        logic        rst;
        logic        run;
        logic [8:0]  ir;
        logic        gnz;
        logic [14:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [14:0] ex(logic irin, logic [2:0] rs, logic re,
                                       logic [2:0] os, logic oe, logic din,
                                       logic go, logic ai, logic gi,
                                       logic asub, logic dn);
        return {irin, rs, re, os, oe, din, go, ai, gi, asub, dn};
    endfunction

    function automatic vec_t mk(string n, logic r, logic rn, logic [8:0] i,
                                logic g, logic [14:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.run = rn; v.ir = i; v.gnz = g; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of stimulus, push its expectation, then sample the
    // combinational outputs well clear of the next rising edge.
    task automatic apply(input vec_t v);
        sb_t s;
        sb_t e;
        int  drivers;
        @(negedge clk);
        reset = v.rst; run = v.run; ir = v.ir; gnz = v.gnz;
        s.name = v.name; s.exp = v.exp;
        sb_q.push_back(s);
        #2;
        e = sb_q.pop_front();
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", e.name, got, e.exp);
        end else begin
            $display("ok   %s: outputs=%h", e.name, got);
        end
        drivers = int'(o_rout_en) + int'(o_dinout) + int'(o_gout);
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("FAIL %s_bus: drivers=%0d required<=1", e.name, drivers);
        end
    endtask

    // Start an instruction from T0 and count cycles (T0 included) up to Done.
    task automatic latency(input string n, input logic [8:0] i, input int req);
        int  cycles;
        logic seen;
        @(negedge clk);
        reset = 1'b0; run = 1'b1; ir = i; gnz = 1'b0;
        #2;
        cycles = 1;
        seen   = o_done;
        while (!seen && cycles < 8) begin
            @(negedge clk);
            run = 1'b0;
            #2;
            cycles++;
            seen = o_done;
        end
        checks++;
        if (!seen || cycles != req) begin
            errors++;
            $display("FAIL lat_%s: cycles=%0d done=%0b required=%0d", n, cycles, seen, req);
        end else begin
            $display("ok   lat_%s: cycles=%0d", n, cycles);
        end
    endtask

    localparam logic [8:0] IR_MV35   = 9'b000_011_101;
    localparam logic [8:0] IR_MVI6   = 9'b001_110_000;
    localparam logic [8:0] IR_SUB12  = 9'b011_001_010;
    localparam logic [8:0] IR_ADD47  = 9'b010_100_111;
    localparam logic [8:0] IR_RES    = 9'b110_001_001;
    localparam logic [8:0] IR_ADD23  = 9'b010_010_011;
    localparam logic [8:0] IR_MVNZ   = 9'b100_010_100;
    localparam logic [8:0] IR_MV77   = 9'b000_111_111;

    logic [14:0] Z;
    logic [14:0] IRIN;
    logic [14:0] DONE;
    logic [14:0] mvnz_g1;

    initial begin
        reset = 1'b1; run = 1'b1; ir = '0; gnz = 1'b0;
        Z    = '0;
        IRIN = ex(1,0,0,0,0,0,0,0,0,0,0);
        DONE = ex(0,0,0,0,0,0,0,0,0,0,1);
`ifdef CTRL_MVNZ_EN
        mvnz_g1 = ex(0,3'd2,1,3'd4,1,0,0,0,0,0,1);
`else
        mvnz_g1 = DONE;
`endif

        // Reset held with Run=1: quiet; released: IRin in T0.
        tbl.push_back(mk("rst_c1",     1,1,9'd0,     0, Z));
        tbl.push_back(mk("rst_c2",     1,1,9'd0,     0, Z));
        tbl.push_back(mk("mv_t0",      0,1,IR_MV35,  0, IRIN));
        tbl.push_back(mk("mv_t1",      0,0,IR_MV35,  0, ex(0,3'd3,1,3'd5,1,0,0,0,0,0,1)));
        tbl.push_back(mk("idle_t0",    0,0,IR_MVI6,  0, Z));
        tbl.push_back(mk("mvi_t0",     0,1,IR_MVI6,  0, IRIN));
        tbl.push_back(mk("mvi_t1",     0,1,IR_MVI6,  0, ex(0,3'd6,1,0,0,1,0,0,0,0,1)));
        tbl.push_back(mk("sub_t0",     0,1,IR_SUB12, 0, IRIN));
        tbl.push_back(mk("sub_t1",     0,1,IR_SUB12, 0, ex(0,0,0,3'd1,1,0,0,1,0,0,0)));
        tbl.push_back(mk("sub_t2",     0,0,IR_SUB12, 0, ex(0,0,0,3'd2,1,0,0,0,1,1,0)));
        tbl.push_back(mk("sub_t3",     0,1,IR_SUB12, 0, ex(0,3'd1,1,0,0,0,1,0,0,0,1)));
        tbl.push_back(mk("sub_back",   0,0,IR_SUB12, 0, Z));
        tbl.push_back(mk("add_t0",     0,1,IR_ADD47, 0, IRIN));
        tbl.push_back(mk("add_t1",     0,0,IR_ADD47, 0, ex(0,0,0,3'd4,1,0,0,1,0,0,0)));
        tbl.push_back(mk("add_rst_t2", 1,0,IR_ADD47, 0, Z));
        tbl.push_back(mk("post_rst_a", 0,0,IR_ADD47, 0, Z));
        tbl.push_back(mk("post_rst_b", 0,0,IR_ADD47, 0, Z));
        tbl.push_back(mk("res_t0",     0,1,IR_RES,   0, IRIN));
        tbl.push_back(mk("res_t1",     0,0,IR_RES,   0, DONE));
        tbl.push_back(mk("add2_t0",    0,1,IR_ADD23, 0, IRIN));
        tbl.push_back(mk("add2_t1",    0,0,IR_ADD23, 0, ex(0,0,0,3'd2,1,0,0,1,0,0,0)));
        tbl.push_back(mk("add2_t2",    0,0,IR_ADD23, 0, ex(0,0,0,3'd3,1,0,0,0,1,0,0)));
        tbl.push_back(mk("add2_t3",    0,0,IR_ADD23, 0, ex(0,3'd2,1,0,0,0,1,0,0,0,1)));
        tbl.push_back(mk("mvnz1_t0",   0,1,IR_MVNZ,  1, IRIN));
        tbl.push_back(mk("mvnz1_t1",   0,0,IR_MVNZ,  1, mvnz_g1));
        tbl.push_back(mk("mvnz0_t0",   0,1,IR_MVNZ,  0, IRIN));
        tbl.push_back(mk("mvnz0_t1",   0,0,IR_MVNZ,  0, DONE));
        tbl.push_back(mk("mvxx_t0",    0,1,IR_MV77,  0, IRIN));
        tbl.push_back(mk("mvxx_t1",    0,0,IR_MV77,  0, ex(0,3'd7,1,3'd7,1,0,0,0,0,0,1)));
        tbl.push_back(mk("idle_end",   0,0,IR_MV77,  0, Z));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
        end

        // Reset asserted in T3 with Run=1 must silence outputs and land in T0.
        apply(mk("r3_t0",   0,1,IR_SUB12, 0, IRIN));
        apply(mk("r3_t1",   0,0,IR_SUB12, 0, ex(0,0,0,3'd1,1,0,0,1,0,0,0)));
        apply(mk("r3_t2",   0,0,IR_SUB12, 0, ex(0,0,0,3'd2,1,0,0,0,1,1,0)));
        apply(mk("r3_rst",  1,1,IR_SUB12, 0, Z));
        apply(mk("r3_idle", 0,0,IR_SUB12, 0, Z));
        apply(mk("r3_run",  0,1,IR_MV35,  0, IRIN));
        apply(mk("r3_mv",   0,0,IR_MV35,  0, ex(0,3'd3,1,3'd5,1,0,0,0,0,0,1)));

        // Instruction latency including T0.
        latency("mv",  IR_MV35,  2);
        latency("mvi", IR_MVI6,  2);
        latency("add", IR_ADD47, 4);
        latency("sub", IR_SUB12, 4);
        latency("res", IR_RES,   2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: sim_time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_control_sequencer
